// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement adder.
package serial_adder_pkg;

    typedef enum logic {C0, C1} carry_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-counter width; a 2-bit word still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder used as the arithmetic slice of the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_twos_adder.sv
// Bit-serial two's-complement adder: LSB-first Mealy FSM whose state is the carry.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_twos_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a,
    input  logic b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic sub,
`endif
    output logic s,
    output logic cout,
    output logic last,
    output logic ovf,
    output logic word_done
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    carry_state_t   state;
    carry_state_t   state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           word_done_next;
    logic           b_eff;
    logic           carry_in;
    logic           fa_cout;
    logic           lsb;

    assign lsb  = (cnt == '0);
    assign last = (cnt == LAST_CNT);

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    logic sub_eff;

    // The LSB cycle uses sub directly so the inverted operand and the +1 carry-in
    // take effect from the first bit; later bits use the latched value.
    assign sub_eff  = lsb ? sub : sub_q;
    assign b_eff    = b ^ sub_eff;
    assign carry_in = lsb ? sub_eff : (state == C1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= 1'b0;
        end else if (en && lsb) begin
            sub_q <= sub;
        end
    end
`else
    assign b_eff    = b;
    assign carry_in = (state == C1);
`endif

    full_adder_cell u_fa (
        .a    (a),
        .b    (b_eff),
        .cin  (carry_in),
        .s    (s),
        .cout (fa_cout)
    );

    assign cout = fa_cout;
    assign ovf  = last & (carry_in ^ fa_cout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= C0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            word_done <= word_done_next;
        end
    end

    // Carry/counter advance; the MSB forces carry back to C0 for the next word.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        word_done_next = 1'b0;
        if (en) begin
            if (last) begin
                state_next     = C0;
                cnt_next       = '0;
                word_done_next = 1'b1;
            end else begin
                state_next = fa_cout ? C1 : C0;
                cnt_next   = cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_twos_adder.sv
// Scoreboard bench for serial_twos_adder (WIDTH=8): directed words and bit vectors.
module tb_serial_twos_adder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic a;
    logic b;
    logic s;
    logic cout;
    logic last;
    logic ovf;
    logic word_done;
    logic chk;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    exp_t   word_q[$];
    logic   bit_q[$];

    logic [W-1:0] col;
    exp_t         snap;

    serial_twos_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .s         (s),
        .cout      (cout),
        .last      (last),
        .ovf       (ovf),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One bit per cycle; inputs change 1ns after the rising edge.
    task automatic drive(input logic ai, input logic bi, input logic ei,
                         input logic ci, input logic es);
        @(posedge clk);
        #1;
        a   = ai;
        b   = bi;
        en  = ei;
        chk = ci;
        if (ci) bit_q.push_back(es);
    endtask

    task automatic send_word(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        word_q.push_back(e);
        for (int i = 0; i < int'(W); i++) drive(x[i], y[i], 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: per-bit checks, word assembly, and word_done-triggered scoreboard pops.
    always @(negedge clk) begin
        if (!reset) begin
            if (chk) begin
                if (bit_q.size() == 0) check("bit_underflow", 1, 0);
                else check("bit_s", {63'd0, s}, {63'd0, bit_q.pop_front()});
            end
            if (!last) check("ovf_not_last", {63'd0, ovf}, 64'd0);
            if (word_done) begin
                if (word_q.size() == 0) begin
                    check("word_done_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = word_q.pop_front();
                    check("word_sum",  {56'd0, snap.sum},  {56'd0, e.sum});
                    check("word_ovf",  {63'd0, snap.ovf},  {63'd0, e.ovf});
                    check("word_cout", {63'd0, snap.cout}, {63'd0, e.cout});
                end
            end
            if (en) begin
                col = {s, col[W-1:1]};
                if (last) begin
                    snap.sum  = col;
                    snap.ovf  = ovf;
                    snap.cout = cout;
                end
            end
        end
    end

    // Directed words: {a, b, {sum, ovf, cout}}
    localparam int NW = 6;
    logic [W-1:0] wa [NW] = '{8'h05, 8'h7F, 8'hFF, 8'hFF, 8'h00, 8'hA5};
    logic [W-1:0] wb [NW] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h00, 8'h5A};
    exp_t         we [NW] = '{{8'h08, 1'b0, 1'b0},
                              {8'h80, 1'b1, 1'b0},
                              {8'h00, 1'b0, 1'b1},
                              {8'hFE, 1'b0, 1'b1},
                              {8'h00, 1'b0, 1'b0},
                              {8'hFF, 1'b0, 1'b0}};

    // First word as raw (a,b) bit pairs and the hand-computed serial sum bits.
    logic [1:0] pv [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11};
    logic       ps [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        chk   = 1'b0;
        col   = '0;
        snap  = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #2;
        check("rst_s",         {63'd0, s},         64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_last",      {63'd0, last},      64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        check("rst_word_done", {63'd0, word_done}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Bit-level add; as a word this is 0xD0 + 0xBC = 0x18C.
        word_q.push_back('{8'h8C, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) drive(pv[i][1], pv[i][0], 1'b1, 1'b1, ps[i]);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) send_word(wa[i], wb[i], we[i]);

        // 0x3C + 0x0F with a 3-cycle en=0 gap carrying garbage inputs.
        word_q.push_back('{8'h4B, 1'b0, 1'b0});
        for (int i = 0; i < int'(W); i++) begin
            if (i == 4) for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            drive(W'(8'h3C) >> i, W'(8'h0F) >> i, 1'b1, 1'b0, 1'b0);
        end

        // Mid-word asynchronous reset with carry=1 pending.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        en    = 1'b0;
        a     = 1'b1;
        b     = 1'b0;
        #1;
        check("arst_s",    {63'd0, s},    64'd1);
        check("arst_cout", {63'd0, cout}, 64'd0);
        check("arst_last", {63'd0, last}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        send_word(8'h05, 8'h03, '{8'h08, 1'b0, 1'b0});

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        send_word(8'h05, 8'h03, '{8'h02, 1'b0, 1'b1});
        send_word(8'h80, 8'h01, '{8'h7F, 1'b1, 1'b1});
        sub = 1'b0;
        send_word(8'h05, 8'h03, '{8'h08, 1'b0, 1'b0});
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50 && (word_q.size() != 0 || bit_q.size() != 0); i++)
            @(posedge clk);
        if (word_q.size() != 0 || bit_q.size() != 0)
            check("drain_timeout", 64'(word_q.size() + bit_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
